pwm_fade_sequencer: RTL and testbench

- Controller that feeds the duty-cycle registers of the PWM peripheral.
- Ramps each channel's working duty toward a target written over SPI, by a programmable step, at a programmable tick rate.
- Commits new duties only on a PWM period boundary, so outputs never glitch mid-period.
- Sits between the SPI register file (targets, step, rate) and the PWM generator's duty inputs.

---
 rtl/pwm_fade_pkg.sv | 25 ++
 rtl/pwm_fade_step.sv | 43 ++++
 rtl/pwm_fade_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// Shared types and helpers for the PWM fade sequencer.
// Optional feature macro: PWM_FADE_GAMMA_EN (adds a perceptual gamma map on
// committed duties; valid for DW=8 only).
package pwm_fade_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2,
    PEND = 2'd3
  } state_e;

`ifdef PWM_FADE_GAMMA_EN
  // Squared-law map with round-up: 0->0, 1->1, 0x80->0x40, 0xFF->0xFF.
  // The largest intermediate (0xFF*0xFF + 0xFF) still fits in 16 bits.
  function automatic logic [7:0] gamma8(input logic [7:0] w);
    logic [15:0] sq;
    sq = (16'(w) * 16'(w)) + 16'd255;
    return sq[15:8];
  endfunction
`endif

endpackage

// File: rtl/pwm_fade_step.sv
// Combinational saturating step unit: moves cur toward tgt by at most step.
// Sums and differences are formed one bit wider than DW so a large step
// can never wrap past the target.
module pwm_fade_step
  import pwm_fade_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] tgt,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] nxt
);

  logic [DW:0] up_sum_s;
  logic [DW:0] dn_diff_s;

  // Next working value, clamped to the target in either direction.
  always_comb begin
    up_sum_s  = {1'b0, cur} + {1'b0, step};
    dn_diff_s = {1'b0, cur} - {1'b0, step};
    nxt       = cur;
    if (step == {DW{1'b0}}) begin
      nxt = cur;
    end else if (tgt > cur) begin
      if (up_sum_s >= {1'b0, tgt}) begin
        nxt = tgt;
      end else begin
        nxt = up_sum_s[DW-1:0];
      end
    end else if (tgt < cur) begin
      // A borrow in the top bit means we stepped below zero: clamp.
      if (dn_diff_s[DW] || (dn_diff_s[DW-1:0] <= tgt)) begin
        nxt = tgt;
      end else begin
        nxt = dn_diff_s[DW-1:0];
      end
    end else begin
      nxt = cur;
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// PWM fade sequencer: ramps per-channel working duties toward their targets
// one step per tick and commits them to the PWM generator only on a period
// boundary. One step unit is time-shared across channels.
// Optional feature macro: PWM_FADE_GAMMA_EN (gamma-mapped commit values;
// settle/busy/done always use the linear working values).
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DW      = DW_DEF,
  parameter int PRESC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [NUM_CH*DW-1:0] target_i,
  input  logic [DW-1:0]        step_i,
  input  logic [PRESC_W-1:0]   rate_div_i,
  input  logic                 period_end_i,
  output logic [NUM_CH*DW-1:0] duty_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [PRESC_W-1:0]   presc_r;
  logic [PRESC_W-1:0]   presc_nxt_s;
  logic [CH_W-1:0]      ch_r;
  logic [CH_W-1:0]      ch_nxt_s;
  logic [DW-1:0]        working_r [NUM_CH];
  logic                 step_we_s;
  logic                 commit_s;
  logic                 settled_s;
  logic [DW-1:0]        cur_s;
  logic [DW-1:0]        tgt_s;
  logic [DW-1:0]        nxt_s;
  logic [NUM_CH*DW-1:0] commit_val_s;

  // Select the channel currently being stepped; target is sampled live.
  always_comb begin
    cur_s = working_r[ch_r];
    tgt_s = target_i[ch_r*DW +: DW];
  end

  pwm_fade_step #(.DW(DW)) u_step (
    .cur  (cur_s),
    .tgt  (tgt_s),
    .step (step_i),
    .nxt  (nxt_s)
  );

  // Settled when every working value equals its target, before any gamma.
  always_comb begin
    settled_s = 1'b1;
    for (int n = 0; n < NUM_CH; n++) begin
      settled_s = settled_s & (working_r[n] == target_i[n*DW +: DW]);
    end
  end

  // Value presented to the PWM generator at commit time.
  always_comb begin
    commit_val_s = {(NUM_CH*DW){1'b0}};
    for (int n = 0; n < NUM_CH; n++) begin
`ifdef PWM_FADE_GAMMA_EN
      commit_val_s[n*DW +: DW] = gamma8(working_r[n]);
`else
      commit_val_s[n*DW +: DW] = working_r[n];
`endif
    end
  end

  // Next-state logic: prescaler ticks in WAIT, channel sweep in STEP,
  // commit on the period boundary in PEND; disable aborts to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    presc_nxt_s = presc_r;
    ch_nxt_s    = ch_r;
    step_we_s   = 1'b0;
    commit_s    = 1'b0;
    if (!enable_i) begin
      state_nxt_s = IDLE;
      presc_nxt_s = {PRESC_W{1'b0}};
      ch_nxt_s    = {CH_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = WAIT;
          presc_nxt_s = {PRESC_W{1'b0}};
        end
        WAIT: begin
          if (presc_r == rate_div_i) begin
            state_nxt_s = STEP;
            presc_nxt_s = {PRESC_W{1'b0}};
            ch_nxt_s    = {CH_W{1'b0}};
          end else begin
            presc_nxt_s = presc_r + PRESC_W'(1);
          end
        end
        STEP: begin
          step_we_s = 1'b1;
          if (ch_r == CH_W'(NUM_CH - 1)) begin
            state_nxt_s = PEND;
            ch_nxt_s    = {CH_W{1'b0}};
          end else begin
            ch_nxt_s = ch_r + CH_W'(1);
          end
        end
        PEND: begin
          if (period_end_i) begin
            commit_s    = 1'b1;
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = PEND;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          presc_nxt_s = {PRESC_W{1'b0}};
          ch_nxt_s    = {CH_W{1'b0}};
        end
      endcase
    end
  end

  // FSM, prescaler and channel index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      presc_r <= {PRESC_W{1'b0}};
      ch_r    <= {CH_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      presc_r <= presc_nxt_s;
      ch_r    <= ch_nxt_s;
    end
  end

  // Working duties: one channel written per STEP cycle, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        working_r[n] <= {DW{1'b0}};
      end
    end else if (step_we_s) begin
      working_r[ch_r] <= nxt_s;
    end
  end

  // Committed duties and handshake flags, updated only at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_o <= {(NUM_CH*DW){1'b0}};
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else if (commit_s) begin
      duty_o <= commit_val_s;
      busy_o <= ~settled_s;
      done_o <= busy_o & settled_s;
    end else begin
      done_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed, table-driven bench for pwm_fade_sequencer (NUM_CH=4, DW=8).
// Expected duties are hand-computed linear working values; the optional
// gamma map (PWM_FADE_GAMMA_EN) is applied by a small bench-side model.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [31:0] target_i;
  logic [7:0]  step_i;
  logic [15:0] rate_div_i;
  logic        period_end_i;
  logic [31:0] duty_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] target;
    logic [7:0]  step;
    logic [15:0] rate;
    logic [31:0] exp_work;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs [10];

  pwm_fade_sequencer #(.NUM_CH(4), .DW(8), .PRESC_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .target_i     (target_i),
    .step_i       (step_i),
    .rate_div_i   (rate_div_i),
    .period_end_i (period_end_i),
    .duty_o       (duty_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_duty(input logic [31:0] w);
    logic [31:0] r;
`ifdef PWM_FADE_GAMMA_EN
    logic [15:0] sq;
`endif
    r = w;
`ifdef PWM_FADE_GAMMA_EN
    for (int n = 0; n < 4; n++) begin
      sq = (16'(w[n*8 +: 8]) * 16'(w[n*8 +: 8])) + 16'd255;
      r[n*8 +: 8] = sq[15:8];
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    enable_i     = 1'b1;
    target_i     = 32'hA5C3_5A3C;
    step_i       = 8'h11;
    rate_div_i   = 16'd0;
    period_end_i = 1'b1;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    enable_i     = 1'b0;
    period_end_i = 1'b0;
    chk("reset_duty", duty_o, 32'h0);
    chk("reset_busy", {31'b0, busy_o}, 32'h0);
    chk("reset_done", {31'b0, done_o}, 32'h0);
  endtask

  // Apply inputs, let a full sequence finish, pulse period_end, check.
  task automatic apply_commit(input string name, input logic [31:0] tgt,
                              input logic [7:0] stp, input logic [15:0] rate,
                              input logic [31:0] exp_work, input logic exp_busy,
                              input logic exp_done);
    enable_i   = 1'b1;
    target_i   = tgt;
    step_i     = stp;
    rate_div_i = rate;
    repeat (9) @(negedge clk);
    period_end_i = 1'b1;
    @(negedge clk);
    period_end_i = 1'b0;
    chk({name, "_duty"}, duty_o, exp_duty(exp_work));
    chk({name, "_busy"}, {31'b0, busy_o}, {31'b0, exp_busy});
    chk({name, "_done"}, {31'b0, done_o}, {31'b0, exp_done});
  endtask

  initial begin
    rst = 1'b0; enable_i = 1'b0; target_i = 32'h0; step_i = 8'h0;
    rate_div_i = 16'd0; period_end_i = 1'b0;

    // Ramp up, ramp down with clamp, idle commit, multi-channel with wide step.
    vecs[0] = '{32'h0000_0010, 8'h04, 16'd0, 32'h0000_0004, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0010, 8'h04, 16'd0, 32'h0000_0008, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0010, 8'h04, 16'd0, 32'h0000_000C, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0010, 8'h04, 16'd0, 32'h0000_0010, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0003, 8'h05, 16'd0, 32'h0000_000B, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0003, 8'h05, 16'd0, 32'h0000_0006, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0003, 8'h05, 16'd0, 32'h0000_0003, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_0003, 8'h05, 16'd0, 32'h0000_0003, 1'b0, 1'b0};
    vecs[8] = '{32'hF002_FF03, 8'h80, 16'd3, 32'h8002_8003, 1'b1, 1'b0};
    vecs[9] = '{32'hF002_FF03, 8'h80, 16'd3, 32'hF002_FF03, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply_commit($sformatf("vec%0d", i), vecs[i].target, vecs[i].step,
                   vecs[i].rate, vecs[i].exp_work, vecs[i].exp_busy,
                   vecs[i].exp_done);
    end

    // Reset in the middle of operation returns everything to zero.
    do_reset();

    // Zero step: nothing moves, busy stays set, done never fires.
    apply_commit("step0_a", 32'h0000_0020, 8'h00, 16'd0, 32'h0, 1'b1, 1'b0);
    apply_commit("step0_b", 32'h0000_0020, 8'h00, 16'd0, 32'h0, 1'b1, 1'b0);

    // Abort during STEP after ch0 has moved to 0x04, then resume.
    do_reset();
    enable_i   = 1'b1;
    target_i   = 32'h0000_0010;
    step_i     = 8'h04;
    rate_div_i = 16'd0;
    repeat (3) @(negedge clk);
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
    period_end_i = 1'b1;
    @(negedge clk);
    period_end_i = 1'b0;
    chk("abort_duty", duty_o, 32'h0);
    chk("abort_busy", {31'b0, busy_o}, 32'h0);
    chk("abort_done", {31'b0, done_o}, 32'h0);
    apply_commit("resume", 32'h0000_0010, 8'h04, 16'd0, 32'h0000_0008, 1'b1, 1'b0);

    // Mid-scale value: 0x80 linear, 0x40 with gamma; done after a busy commit.
    do_reset();
    apply_commit("gam_a", 32'h0000_0080, 8'h40, 16'd0, 32'h0000_0040, 1'b1, 1'b0);
    apply_commit("gam_b", 32'h0000_0080, 8'h40, 16'd0, 32'h0000_0080, 1'b0, 1'b1);
    @(negedge clk);
    chk("gam_done_clear", {31'b0, done_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
